word_display: RTL and testbench

- Drives a 4-digit, common-anode, time-multiplexed 7-segment display with one of eight fixed 4-character status words for the Battleship game.
- The word is chosen by `wordSelect`.
- Each player board instantiates one copy, fed by game-control logic.
- Purely synchronous: one clock, no handshake.

---
 rtl/word_display.sv | 130 +++++++++++++
 tb/tb_word_display.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/word_display.sv
// word_display
//   Drives a 4-digit, common-anode, time-multiplexed 7-segment display with
//   one of eight fixed 4-character status words.
//
//   Each digit is lit for DIGIT_CYCLES consecutive clocks. The scan order is
//   left to right (an[3] down to an[0]). Both outputs are registered, so a
//   digit index or wordSelect change shows up one edge later.
//
// Ports
//   clk         system clock, rising edge
//   clr_n       synchronous active-low reset
//   wordSelect  word index 0..7
//   seg         segments, active-low, {dp,g,f,e,d,c,b,a}
//   an          digit anodes, active-low, an[3] = leftmost digit
module word_display #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [2:0] wordSelect,
    output logic [7:0] seg,
    output logic [3:0] an
);

    // A one-cycle dwell still needs a 1-bit counter that simply stays at 0.
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    typedef enum logic [3:0] {
        G_BLANK, G_S, G_H, G_I, G_P, G_F, G_R, G_E,
        G_T, G_L, G_O, G_G, G_D, G_A, G_DASH
    } glyph_t;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    glyph_t        glyph;
    logic [6:0]    lit;      // {g,f,e,d,c,b,a}, 1 = segment on
    logic [3:0]    an_next;
    logic [7:0]    seg_next;

    // Word ROM: {word, position} -> glyph. Position 0 is the leftmost char.
    always_comb begin
        glyph = G_BLANK;
        case ({wordSelect, idx})
            5'b001_00: glyph = G_S;
            5'b001_01: glyph = G_H;
            5'b001_10: glyph = G_I;
            5'b001_11: glyph = G_P;
            5'b010_00: glyph = G_F;
            5'b010_01: glyph = G_I;
            5'b010_10: glyph = G_R;
            5'b010_11: glyph = G_E;
            5'b011_00: glyph = G_BLANK;
            5'b011_01: glyph = G_H;
            5'b011_10: glyph = G_I;
            5'b011_11: glyph = G_T;
            5'b100_00: glyph = G_L;
            5'b100_01: glyph = G_O;
            5'b100_10: glyph = G_S;
            5'b100_11: glyph = G_E;
            5'b101_00: glyph = G_G;
            5'b101_01: glyph = G_O;
            5'b101_10: glyph = G_O;
            5'b101_11: glyph = G_D;
            5'b110_00: glyph = G_D;
            5'b110_01: glyph = G_E;
            5'b110_10: glyph = G_A;
            5'b110_11: glyph = G_D;
            5'b111_00: glyph = G_DASH;
            5'b111_01: glyph = G_DASH;
            5'b111_10: glyph = G_DASH;
            5'b111_11: glyph = G_DASH;
            default:   glyph = G_BLANK;
        endcase
    end

    // Glyph decoder, lit pattern in g..a order.
    always_comb begin
        lit = 7'b0000000;
        case (glyph)
            G_S:     lit = 7'b1101101;
            G_H:     lit = 7'b1110110;
            G_I:     lit = 7'b0110000;
            G_P:     lit = 7'b1110011;
            G_F:     lit = 7'b1110001;
            G_R:     lit = 7'b1010000;
            G_E:     lit = 7'b1111001;
            G_T:     lit = 7'b1111000;
            G_L:     lit = 7'b0111000;
            G_O:     lit = 7'b0111111;
            G_G:     lit = 7'b0111101;
            G_D:     lit = 7'b1011110;
            G_A:     lit = 7'b1110111;
            G_DASH:  lit = 7'b1000000;
            default: lit = 7'b0000000;
        endcase
        // Active-low outputs; decimal point always off.
        seg_next = {1'b1, ~lit};
    end

    always_comb begin
        an_next = 4'b1111;
        case (idx)
            2'd0:    an_next = 4'b0111;
            2'd1:    an_next = 4'b1011;
            2'd2:    an_next = 4'b1101;
            2'd3:    an_next = 4'b1110;
            default: an_next = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
            idx <= 2'd0;
            an  <= 4'b1111;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_display.sv
module tb_word_display;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [2:0] wordSelect;
    logic [7:0] seg, seg1;
    logic [3:0] an, an1;

    int checks   = 0;
    int failures = 0;

    // bench reference state (D=4 and D=1 instances)
    int         m_cnt;
    logic [1:0] m_idx;
    logic [1:0] mb_idx;
    logic [7:0] es, es1;
    logic [3:0] ea, ea1;

    word_display #(.DIGIT_CYCLES(4)) dut (
        .clk(clk), .clr_n(clr_n), .wordSelect(wordSelect), .seg(seg), .an(an)
    );

    word_display #(.DIGIT_CYCLES(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .wordSelect(wordSelect), .seg(seg1), .an(an1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph_seg(input logic [2:0] w, input logic [1:0] p);
        logic [31:0] word;
        case (w)
            3'd0:    word = 32'hFF_FF_FF_FF;
            3'd1:    word = 32'h92_89_CF_8C;
            3'd2:    word = 32'h8E_CF_AF_86;
            3'd3:    word = 32'hFF_89_CF_87;
            3'd4:    word = 32'hC7_C0_92_86;
            3'd5:    word = 32'hC2_C0_C0_A1;
            3'd6:    word = 32'hA1_86_88_A1;
            default: word = 32'hBF_BF_BF_BF;
        endcase
        return word[31 - 8*p -: 8];
    endfunction

    function automatic logic [3:0] an_of(input logic [1:0] p);
        case (p)
            2'd0:    return 4'b0111;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; advances the reference and samples 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!clr_n) begin
            ea = 4'hF; es = 8'hFF; m_cnt = 0; m_idx = 2'd0;
            ea1 = 4'hF; es1 = 8'hFF; mb_idx = 2'd0;
        end else begin
            ea = an_of(m_idx);
            es = glyph_seg(wordSelect, m_idx);
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = m_idx + 2'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            ea1 = an_of(mb_idx);
            es1 = glyph_seg(wordSelect, mb_idx);
            mb_idx = mb_idx + 2'd1;
        end
        #1;
    endtask

    initial begin
        logic [3:0] prev_an;
        int         run_len;
        bit         seen_change;

        m_cnt = 0; m_idx = 2'd0; mb_idx = 2'd0;
        clr_n = 1'b0;
        wordSelect = 3'd1;

        // reset hold
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an",   {4'h0, an},   8'h0F);
            check("rst_seg",  seg,          8'hFF);
            check("rst_an1",  {4'h0, an1},  8'h0F);
            check("rst_seg1", seg1,         8'hFF);
        end

        // release: SHIP scan with 4-cycle dwell
        clr_n = 1'b1;
        step();
        check("rel_an",   {4'h0, an},  8'h07);
        check("rel_seg",  seg,         8'h92);
        check("d1_an_e1", {4'h0, an1}, 8'h07);
        check("d1_seg_e1", seg1,       8'h92);
        step();
        check("hold_an2", {4'h0, an},  8'h07);
        check("d1_an_e2", {4'h0, an1}, 8'h0B);
        check("d1_seg_e2", seg1,       8'h89);
        step();
        step();
        check("hold_an4", {4'h0, an},  8'h07);
        check("hold_seg4", seg,        8'h92);
        step();
        check("dig1_an",  {4'h0, an},  8'h0B);
        check("dig1_seg", seg,         8'h89);
        repeat (4) step();
        check("dig2_an",  {4'h0, an},  8'h0D);
        check("dig2_seg", seg,         8'hCF);
        repeat (4) step();
        check("dig3_an",  {4'h0, an},  8'h0E);
        check("dig3_seg", seg,         8'h8C);
        repeat (4) step();
        check("wrap_an",  {4'h0, an},  8'h07);
        check("wrap_seg", seg,         8'h92);

        // sweep all words across full scans
        for (int w = 0; w < 8; w++) begin
            wordSelect = 3'(w);
            for (int i = 0; i < 16; i++) begin
                step();
                check("sweep_an",  {4'h0, an}, {4'h0, ea});
                check("sweep_seg", seg,        es);
            end
        end

        // mid-digit word change at index 2
        wordSelect = 3'd4;
        for (int i = 0; i < 20; i++) begin
            if (m_idx == 2'd2 && m_cnt == 2) break;
            step();
        end
        check("mid_pre_an",  {4'h0, an}, 8'h0D);
        check("mid_pre_seg", seg,        8'h92);
        wordSelect = 3'd6;
        step();
        check("mid_chg_an",  {4'h0, an}, 8'h0D);
        check("mid_chg_seg", seg,        8'h88);
        step();
        check("mid_hold_an",  {4'h0, an}, 8'h0D);
        check("mid_hold_seg", seg,        8'h88);
        step();
        check("mid_next_an",  {4'h0, an}, 8'h0E);
        check("mid_next_seg", seg,        8'hA1);

        // one-cycle reset while index 3 is lit
        clr_n = 1'b0;
        step();
        check("mrst_an",  {4'h0, an}, 8'h0F);
        check("mrst_seg", seg,        8'hFF);
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_d0_an",  {4'h0, an}, 8'h07);
            check("mrst_d0_seg", seg,        8'hA1);
        end
        step();
        check("mrst_d1_an",  {4'h0, an}, 8'h0B);
        check("mrst_d1_seg", seg,        8'h86);

        // long run with random word changes
        prev_an = an;
        run_len = 1;
        seen_change = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wordSelect = 3'($urandom_range(0, 7));
            step();
            check("run_onehot", 8'($countones(~an)), 8'd1);
            check("run_dp",     {7'd0, seg[7]},      8'd1);
            check("run_an",     {4'h0, an},          {4'h0, ea});
            check("run_seg",    seg,                 es);
            check("run_an1",    {4'h0, an1},         {4'h0, ea1});
            check("run_seg1",   seg1,                es1);
            check("run_dp1",    {7'd0, seg1[7]},     8'd1);
            if (an === prev_an) begin
                run_len++;
            end else begin
                if (seen_change) check("run_dwell", 8'(run_len), 8'd4);
                seen_change = 1'b1;
                run_len = 1;
                prev_an = an;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
